// File: rtl/tmip_pkg.sv
// Shared action/size codes and scheduler state encoding for the TMIP engine front end.
package tmip_pkg;

    localparam int unsigned MAX_ACT_DEF = 8;

    typedef enum logic [2:0] {
        ACT_GRAY_MAX = 3'd0,
        ACT_GRAY_AVG = 3'd1,
        ACT_GRAY_WGT = 3'd2,
        ACT_MAXPOOL  = 3'd3,
        ACT_NEG      = 3'd4,
        ACT_FLIP     = 3'd5,
        ACT_FILTER   = 3'd6,
        ACT_XCORR    = 3'd7
    } act_e;

    localparam logic [1:0] SZ_4X4   = 2'd0;
    localparam logic [1:0] SZ_8X8   = 2'd1;
    localparam logic [1:0] SZ_16X16 = 2'd2;
    localparam logic [1:0] SZ_ILL   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StFinish
    } state_e;

endpackage

// File: rtl/tmip_action_buf.sv
// Action code register file: sequential write with running count, two combinational
// read ports (idx and idx+1) for look-ahead folding.
module tmip_action_buf
    import tmip_pkg::*;
#(
    parameter int unsigned MAX_ACT = MAX_ACT_DEF,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [2:0]       wr_data_i,
    input  logic [CNT_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic [2:0]       rd_data0_o,
    output logic [2:0]       rd_data1_o
);

    logic [2:0]       mem_q [MAX_ACT];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_nxt;
    logic             wr_ok;

    // A clear and a write in the same cycle start a fresh set at slot 0.
    assign wr_ptr  = clr_i ? '0 : count_q;
    assign full_o  = (count_q == CNT_W'(MAX_ACT));
    assign wr_ok   = wr_en_i && (wr_ptr != CNT_W'(MAX_ACT));
    assign count_o = count_q;
    assign rd_nxt  = rd_idx_i + CNT_W'(1);

    always_comb begin
        count_d = clr_i ? '0 : count_q;
        if (wr_ok) begin
            count_d = wr_ptr + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            for (int i = 0; i < int'(MAX_ACT); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < int'(MAX_ACT); i++) begin
                if (wr_ok && (wr_ptr == CNT_W'(i))) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_data0_o = '0;
        rd_data1_o = '0;
        for (int i = 0; i < int'(MAX_ACT); i++) begin
            if (rd_idx_i == CNT_W'(i)) begin
                rd_data0_o = mem_q[i];
            end
            if (rd_nxt == CNT_W'(i)) begin
                rd_data1_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/tmip_action_scheduler.sv
// Captures one action set, folds redundant actions and issues the rest to the engine
// one at a time over a valid/ready + done handshake.
module tmip_action_scheduler
    import tmip_pkg::*;
#(
    parameter int unsigned MAX_ACT = MAX_ACT_DEF,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sz_valid,
    input  logic [1:0] image_size,
    input  logic       in_valid2,
    input  logic [2:0] action,
    output logic       op_valid,
    input  logic       op_ready,
    output logic [2:0] op_code,
    output logic [1:0] op_size,
    output logic       op_flip,
    input  logic       eng_done,
    output logic       busy,
    output logic       seq_done,
    output logic       err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [1:0]       cur_size_q, cur_size_d;
    logic             flip_pend_q, flip_pend_d;
    logic             end_q, end_d;
    logic             err_q, err_d;
    logic             op_valid_q, op_valid_d;
    logic [2:0]       op_code_q, op_code_d;
    logic [1:0]       op_size_q, op_size_d;
    logic             op_flip_q, op_flip_d;

    logic             buf_clr, buf_wr, buf_full;
    logic [CNT_W-1:0] count;
    logic [2:0]       rd0, rd1;
    act_e             cur_act;
    logic             issue, err_set, err_clr;

    tmip_action_buf #(
        .MAX_ACT (MAX_ACT),
        .CNT_W   (CNT_W)
    ) u_buf (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (buf_clr),
        .wr_en_i    (buf_wr),
        .wr_data_i  (action),
        .rd_idx_i   (idx_q),
        .count_o    (count),
        .full_o     (buf_full),
        .rd_data0_o (rd0),
        .rd_data1_o (rd1)
    );

    assign cur_act = act_e'(rd0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_size_d  = cur_size_q;
        flip_pend_d = flip_pend_q;
        end_d       = end_q;
        op_valid_d  = op_valid_q;
        op_code_d   = op_code_q;
        op_size_d   = op_size_q;
        op_flip_d   = op_flip_q;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        issue       = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        busy        = (state_q == StLoad) || (state_q == StIssue) || (state_q == StWait);
        seq_done    = 1'b0;

        if (!busy && sz_valid) begin
            cur_size_d = (image_size == SZ_ILL) ? SZ_16X16 : image_size;
            err_set    = (image_size == SZ_ILL);
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid2) begin
                    buf_clr     = 1'b1;
                    buf_wr      = 1'b1;
                    err_clr     = 1'b1;
                    idx_d       = '0;
                    flip_pend_d = 1'b0;
                    end_d       = 1'b0;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                if (in_valid2) begin
                    buf_wr  = 1'b1;
                    err_set = buf_full;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (in_valid2) begin
                    err_set = 1'b1;
                end
                if (op_valid_q) begin
                    if (op_ready) begin
                        if (op_code_q == ACT_MAXPOOL) begin
                            cur_size_d = cur_size_q - 2'd1;
                        end
                        end_d      = (op_code_q == ACT_XCORR);
                        idx_d      = idx_q + CNT_W'(1);
                        op_valid_d = 1'b0;
                        op_code_d  = '0;
                        op_size_d  = '0;
                        op_flip_d  = 1'b0;
                        state_d    = StWait;
                    end
                end else if (end_q) begin
                    state_d = StFinish;
                end else if (idx_q == count) begin
                    err_set = 1'b1;
                    state_d = StFinish;
                end else begin
                    if ((idx_q == '0) && (rd0 > ACT_GRAY_WGT)) begin
                        err_set = 1'b1;
                    end
                    // Skipped actions advance idx this cycle; issued ones advance on handshake.
                    unique case (cur_act)
                        ACT_GRAY_MAX, ACT_GRAY_AVG, ACT_GRAY_WGT: begin
                            if (idx_q == '0) begin
                                issue = 1'b1;
                            end else begin
                                err_set = 1'b1;
                                idx_d   = idx_q + CNT_W'(1);
                            end
                        end
                        ACT_MAXPOOL: begin
                            if (cur_size_q == SZ_4X4) idx_d = idx_q + CNT_W'(1);
                            else                      issue = 1'b1;
                        end
                        ACT_NEG: begin
                            if (((idx_q + CNT_W'(1)) < count) && (rd1 == ACT_NEG)) begin
                                idx_d = idx_q + CNT_W'(2);
                            end else begin
                                issue = 1'b1;
                            end
                        end
                        ACT_FLIP: begin
                            flip_pend_d = !flip_pend_q;
                            idx_d       = idx_q + CNT_W'(1);
                        end
                        ACT_FILTER, ACT_XCORR: issue = 1'b1;
                    endcase
                    if (issue) begin
                        op_valid_d = 1'b1;
                        op_code_d  = rd0;
                        op_size_d  = cur_size_q;
                        op_flip_d  = (cur_act == ACT_XCORR) && flip_pend_q;
                    end
                end
            end
            StWait: begin
                if (in_valid2) begin
                    err_set = 1'b1;
                end
                if (eng_done) begin
                    state_d = StIssue;
                end
            end
            StFinish: begin
                seq_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cur_size_q  <= '0;
            flip_pend_q <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
            op_valid_q  <= 1'b0;
            op_code_q   <= '0;
            op_size_q   <= '0;
            op_flip_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_size_q  <= cur_size_d;
            flip_pend_q <= flip_pend_d;
            end_q       <= end_d;
            err_q       <= err_d;
            op_valid_q  <= op_valid_d;
            op_code_q   <= op_code_d;
            op_size_q   <= op_size_d;
            op_flip_q   <= op_flip_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_code  = op_code_q;
    assign op_size  = op_size_q;
    assign op_flip  = op_flip_q;
    assign err      = err_q;

endmodule

// File: tb/tb_tmip_action_scheduler.sv
// Directed bench for tmip_action_scheduler: loads action sets, plays a simple engine and
// checks the issued ops, seq_done, err and reset behaviour against hand-computed tables.
module tb_tmip_action_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sz_valid = 1'b0;
    logic [1:0] image_size = '0;
    logic       in_valid2 = 1'b0;
    logic [2:0] action = '0;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic [2:0] op_code;
    logic [1:0] op_size;
    logic       op_flip;
    logic       eng_done = 1'b0;
    logic       busy;
    logic       seq_done;
    logic       err;

    int total = 0;
    int bad = 0;

    int acts [16];
    int ec [8];
    int es [8];
    int ef [8];

    tmip_action_scheduler #(
        .MAX_ACT (8),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sz_valid   (sz_valid),
        .image_size (image_size),
        .in_valid2  (in_valid2),
        .action     (action),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_size    (op_size),
        .op_flip    (op_flip),
        .eng_done   (eng_done),
        .busy       (busy),
        .seq_done   (seq_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic exp_op(input int i, input int c, input int s, input int f);
        ec[i] = c;
        es[i] = s;
        ef[i] = f;
    endtask

    task automatic load_set(input bit do_sz, input logic [1:0] sz, input int n);
        if (do_sz) begin
            @(negedge clk);
            sz_valid   = 1'b1;
            image_size = sz;
        end
        @(negedge clk);
        sz_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid2 = 1'b1;
            action    = acts[i][2:0];
            @(negedge clk);
        end
        in_valid2 = 1'b0;
    endtask

    // Engine model: accepts each offered op at once, signals done three cycles later.
    task automatic serve(input int n_exp);
        int k = 0;
        int dcnt = 0;
        bit seen = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            @(negedge clk);
            op_ready = 1'b0;
            eng_done = 1'b0;
            if (seq_done) begin
                seen = 1'b1;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) eng_done = 1'b1;
            end else if (op_valid) begin
                if (k < n_exp) begin
                    chk("op_code", 32'(op_code), 32'(ec[k]));
                    chk("op_size", 32'(op_size), 32'(es[k]));
                    chk("op_flip", 32'(op_flip), 32'(ef[k]));
                end
                op_ready = 1'b1;
                k++;
                dcnt = 3;
            end
        end
        chk("n_ops", 32'(k), 32'(n_exp));
        chk("seq_done", 32'(seen), 32'd1);
        chk("busy_fin", 32'(busy), 32'd0);
    endtask

    task automatic wait_op(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = op_valid;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", {op_valid, op_code, op_size, op_flip, busy, seq_done, err}, 32'd0);
        rst = 1'b0;

        // Grayscale, maxpool, filter, xcorr at 8x8.
        acts[0] = 0; acts[1] = 3; acts[2] = 6; acts[3] = 7;
        exp_op(0, 0, 1, 0); exp_op(1, 3, 1, 0); exp_op(2, 6, 0, 0); exp_op(3, 7, 0, 0);
        load_set(1'b1, 2'd1, 4);
        chk("busy_load", 32'(busy), 32'd1);
        serve(4);
        chk("err_t1", 32'(err), 32'd0);

        // Maxpool skipped at 4x4, pending flip rides on xcorr.
        acts[0] = 1; acts[1] = 3; acts[2] = 5; acts[3] = 7;
        exp_op(0, 1, 0, 0); exp_op(1, 7, 0, 1);
        load_set(1'b1, 2'd0, 4);
        serve(2);
        chk("err_t2", 32'(err), 32'd0);

        // Negative pair and flip pair cancel.
        acts[0] = 2; acts[1] = 4; acts[2] = 4; acts[3] = 5; acts[4] = 5; acts[5] = 7;
        exp_op(0, 2, 2, 0); exp_op(1, 7, 2, 0);
        load_set(1'b1, 2'd2, 6);
        serve(2);
        chk("err_t3", 32'(err), 32'd0);

        // Illegal size: err raised, size forced to 16x16, first beat clears err.
        @(negedge clk);
        sz_valid   = 1'b1;
        image_size = 2'd3;
        @(negedge clk);
        sz_valid = 1'b0;
        chk("err_illsz", 32'(err), 32'd1);
        acts[0] = 0; acts[1] = 3; acts[2] = 7;
        exp_op(0, 0, 2, 0); exp_op(1, 3, 2, 0); exp_op(2, 7, 1, 0);
        load_set(1'b0, 2'd0, 3);
        serve(3);
        chk("err_t4", 32'(err), 32'd0);

        // Engine stall: fields must hold while op_ready is low; early done ignored.
        acts[0] = 6; acts[1] = 7;
        exp_op(0, 6, 1, 0); exp_op(1, 7, 1, 0);
        load_set(1'b1, 2'd1, 2);
        wait_op("stall_ov");
        eng_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            eng_done = 1'b0;
            chk("stall_hold", {op_valid, op_code, op_size, op_flip}, {1'b1, 3'd6, 2'd1, 1'b0});
        end
        serve(2);
        chk("err_t5", 32'(err), 32'd1);

        // Nine beats, no xcorr: ninth dropped, buffer exhaustion ends the set.
        acts[0] = 0;
        for (int i = 1; i < 8; i++) acts[i] = 5;
        acts[8] = 6;
        exp_op(0, 0, 1, 0);
        load_set(1'b1, 2'd1, 9);
        chk("err_ovf", 32'(err), 32'd1);
        serve(1);
        chk("err_t6", 32'(err), 32'd1);

        // Reset while waiting on the engine.
        acts[0] = 0; acts[1] = 7;
        load_set(1'b1, 2'd0, 2);
        wait_op("rst_ov");
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("busy_wait", {busy, op_valid}, {1'b1, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", {op_valid, op_code, op_size, op_flip, busy, seq_done, err}, 32'd0);
        acts[0] = 1; acts[1] = 7;
        exp_op(0, 1, 2, 0); exp_op(1, 7, 2, 0);
        load_set(1'b1, 2'd2, 2);
        serve(2);
        chk("err_t7", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
